// File: rtl/w21_col_mac_seq_pkg.sv
// Shared constants, FSM encoding and saturation limits for the W21 column MAC sequencer.
package w21_col_mac_seq_pkg;

    localparam int N_IN   = 300;
    localparam int ADDR_W = 9;
    localparam int D_W    = 21;
    localparam int FRAC   = 10;
    localparam int ACC_W  = 51;
    localparam int PROD_W = 2 * D_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic signed [D_W-1:0] SAT_MAX = {1'b0, {(D_W-1){1'b1}}};
    localparam logic signed [D_W-1:0] SAT_MIN = {1'b1, {(D_W-1){1'b0}}};

endpackage

// File: rtl/w21_col_mac_seq_mac_sat_21.sv
// Product register, wide accumulator and floor-rescale/saturate of one column sum.
module mac_sat_21
    import w21_col_mac_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sample,
    input  logic                  clear,
    input  logic                  load,
    input  logic signed [D_W-1:0] w_in,
    input  logic signed [D_W-1:0] x_in,
    output logic                  pending,
    output logic signed [D_W-1:0] result
);

    logic signed [PROD_W-1:0] prod_p0;
    logic                     vld_p0;
    logic signed [ACC_W-1:0]  acc_p1;
    logic signed [ACC_W-1:0]  prod_ext;

    // Arithmetic shift floors toward minus infinity; no rounding is applied.
    function automatic logic signed [D_W-1:0] rescale_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] tmp;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        tmp = acc >>> FRAC;
        hi  = {{(ACC_W-D_W){SAT_MAX[D_W-1]}}, SAT_MAX};
        lo  = {{(ACC_W-D_W){SAT_MIN[D_W-1]}}, SAT_MIN};
        if (tmp > hi)
            return SAT_MAX;
        else if (tmp < lo)
            return SAT_MIN;
        else
            return tmp[D_W-1:0];
    endfunction

    assign prod_ext = {{(ACC_W-PROD_W){prod_p0[PROD_W-1]}}, prod_p0};
    assign pending  = vld_p0;

    // Stage p0: product register; stage p1: accumulator; result holds until the next load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prod_p0 <= '0;
            vld_p0  <= 1'b0;
            acc_p1  <= '0;
            result  <= '0;
        end else begin
            vld_p0 <= sample;
            if (sample)
                prod_p0 <= w_in * x_in;
            if (clear)
                acc_p1 <= '0;
            else if (vld_p0)
                acc_p1 <= acc_p1 + prod_ext;
            if (load)
                result <= rescale_sat(acc_p1);
        end
    end

endmodule

// File: rtl/w21_col_mac_seq.sv
// Column sequencer: walks the weight ROM / activation buffer address and feeds the MAC.
module w21_col_mac_seq
    import w21_col_mac_seq_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic [ADDR_W-1:0]       adrs_clm,
    input  logic signed [D_W-1:0]   w_in,
    input  logic signed [D_W-1:0]   x_in,
    output logic                    busy,
    output logic                    done,
    output logic signed [D_W-1:0]   result
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_IN - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] addr;
    logic              accept;
    logic              pending;

    assign accept = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // The address wraps to 0 after the last entry so it never leaves the ROM range.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            addr <= '0;
        else if (accept)
            addr <= '0;
        else if (state == RUN)
            addr <= (addr == LAST_ADDR) ? '0 : addr + 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (addr == LAST_ADDR) state_nx = DRAIN;
            DRAIN:   if (!pending) state_nx = DONE;
            DONE:    state_nx = start ? RUN : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
        adrs_clm = (state == RUN) ? addr : '0;
    end

    // DRAIN waits one extra edge for the last product to land in the accumulator.
    mac_sat_21 u_mac (
        .clk     (clk),
        .rst     (rst),
        .sample  (state == RUN),
        .clear   (accept),
        .load    ((state == DRAIN) && !pending),
        .w_in    (w_in),
        .x_in    (x_in),
        .pending (pending),
        .result  (result)
    );

endmodule

// File: tb/tb_w21_col_mac_seq.sv
// Randomized scoreboard bench for w21_col_mac_seq with a plain-arithmetic column-sum model.
module tb_w21_col_mac_seq;
    import w21_col_mac_seq_pkg::*;

    localparam longint MAXV = (longint'(1) <<< (D_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (D_W - 1));

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  start;
    logic [ADDR_W-1:0]     adrs_clm;
    logic signed [D_W-1:0] w_in;
    logic signed [D_W-1:0] x_in;
    logic                  busy;
    logic                  done;
    logic signed [D_W-1:0] result;

    int wv[N_IN];
    int xv[N_IN];

    typedef struct {
        longint res;
        int     cyc;
    } exp_t;

    exp_t   sb[$];
    int     checks   = 0;
    int     failures = 0;
    int     cyc      = 0;
    longint last_exp = 0;

    w21_col_mac_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .adrs_clm (adrs_clm),
        .w_in     (w_in),
        .x_in     (x_in),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Combinational ROM / activation buffer stand-ins.
    always_comb begin
        w_in = '0;
        x_in = '0;
        if (int'(adrs_clm) < N_IN) begin
            w_in = wv[adrs_clm][D_W-1:0];
            x_in = xv[adrs_clm][D_W-1:0];
        end
    end

    function automatic longint model();
        longint s = 0;
        for (int i = 0; i < N_IN; i++)
            s += longint'(wv[i]) * longint'(xv[i]);
        s = s >>> FRAC;
        if (s > MAXV) return MAXV;
        if (s < MINV) return MINV;
        return s;
    endfunction

    function automatic int rnd_signed(int k);
        return int'($urandom_range(0, (1 << (k + 1)) - 1)) - (1 << k);
    endfunction

    task automatic check(string name, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done actual=1 required=0 at cycle %0d", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("result", longint'(result), e.res);
                check("latency", longint'(cyc), longint'(e.cyc));
                last_exp = e.res;
            end
        end
    end

    task automatic kick();
        exp_t e;
        e.res = model();
        e.cyc = cyc + 1 + N_IN + 2;
        sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(string name);
        int n = 0;
        while (sb.size() != 0 && n < N_IN + 50) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout pending=%0d required=0", name, sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_done(string name);
        int n = 0;
        do begin
            @(negedge clk);
            #1;
            n++;
        end while (done !== 1'b1 && n < N_IN + 50);
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout done=%0b required=1", name, done);
        end
    endtask

    task automatic fill_rand(int kw, int kx);
        for (int i = 0; i < N_IN; i++) begin
            wv[i] = rnd_signed(kw);
            xv[i] = rnd_signed(kx);
        end
    endtask

    task automatic setup_single(int a, int w, int x);
        for (int i = 0; i < N_IN; i++) begin
            wv[i] = rnd_signed(20);
            xv[i] = 0;
        end
        wv[a] = w;
        xv[a] = x;
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        for (int i = 0; i < N_IN; i++) begin
            wv[i] = 0;
            xv[i] = 0;
        end
        repeat (2) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_result", longint'(result), 0);
        check("rst_adrs", longint'(adrs_clm), 0);
        rst = 1'b0;
        @(negedge clk);

        // Zero activations: address sweep 0..N_IN-1 then two DRAIN cycles at address 0.
        begin
            int idx = 0;
            int bad = 0;
            fill_rand(20, 0);
            for (int i = 0; i < N_IN; i++) xv[i] = 0;
            kick();
            for (int n = 0; n < N_IN + 50; n++) begin
                if (busy) begin
                    if (int'(adrs_clm) != ((idx < N_IN) ? idx : 0)) bad++;
                    idx++;
                end else if (idx > 0) begin
                    break;
                end
                @(negedge clk);
            end
            check("sweep_len", longint'(idx), longint'(N_IN + 2));
            check("sweep_addr_bad", longint'(bad), 0);
            wait_idle("zero_x");
            check("zero_result", longint'(result), 0);
        end

        setup_single(253, 2232, 1024);
        kick();
        wait_idle("dir_253");
        check("dir_253", longint'(result), 2232);

        setup_single(0, -181, -1024);
        kick();
        wait_idle("dir_0");
        check("dir_0", longint'(result), 181);

        for (int i = 0; i < N_IN; i++) begin
            wv[i] = 32'h000F_FFFF;
            xv[i] = 32'h000F_FFFF;
        end
        kick();
        wait_idle("sat_pos");
        check("sat_pos", longint'(result), 1048575);
        for (int i = 0; i < N_IN; i++) xv[i] = -1048575;
        kick();
        wait_idle("sat_neg");
        check("sat_neg", longint'(result), -1048576);

        // Starts while busy must be ignored.
        setup_single(253, 2232, 1024);
        kick();
        repeat (49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (149) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle("ignore_start");
        check("ignore_start_result", longint'(result), 2232);
        check("ignore_start_busy", longint'(busy), 0);

        // Random pairs; the second of each pair restarts in the DONE cycle.
        for (int r = 0; r < 4; r++) begin
            fill_rand($urandom_range(6, 14), $urandom_range(6, 14));
            kick();
            wait_done("rand_a");
            fill_rand($urandom_range(4, 20), $urandom_range(4, 12));
            kick();
            check("hold_result", longint'(result), last_exp);
            check("restart_busy", longint'(busy), 1);
            wait_idle("rand_b");
        end

        // Asynchronous reset mid-run aborts with no done.
        setup_single(253, 2232, 1024);
        kick();
        wait_idle("pre_rst");
        kick();
        repeat (149) @(negedge clk);
        #3 rst = 1'b1;
        #1;
        check("arst_busy", longint'(busy), 0);
        check("arst_done", longint'(done), 0);
        check("arst_result", longint'(result), 0);
        check("arst_adrs", longint'(adrs_clm), 0);
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (N_IN + 10) @(negedge clk);
        check("post_rst_busy", longint'(busy), 0);
        check("post_rst_result", longint'(result), 0);

        fill_rand(10, 10);
        kick();
        wait_idle("post_rst_run");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
